preamble_sync_controller: RTL and testbench

Sequencing controller that sits behind the preamble detector. It consumes the detector's 2-bit trigger alongside the same sample stream. It confirms a preamble by checking that triggers recur at the expected symbol period, and latches the preamble polarity. It then gates exactly one payload frame of polarity-corrected samples onto an AXI-Stream master with `tlast`, and returns to searching.

---
 rtl/preamble_sync_controller.sv | 212 +++++++++++++++++++++
 tb/tb_preamble_sync_controller.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/preamble_sync_controller.sv
// Preamble sequencing controller: confirms periodic detector triggers, latches polarity,
// then gates one polarity-corrected payload frame onto an AXI-Stream master.
module preamble_sync_controller #(
  parameter int unsigned C_S00_AXIS_TDATA_WIDTH = 32,
  parameter int unsigned C_M00_AXIS_TDATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH              = 16
) (
  input  logic                              s00_axis_aclk,
  input  logic                              s00_axis_aresetn,
  input  logic                              s00_axis_tvalid,
  input  logic [C_S00_AXIS_TDATA_WIDTH-1:0] s00_axis_tdata,
  output logic                              s00_axis_tready,
  input  logic [1:0]                        trigger,
  input  logic                              enable,
  input  logic [CNT_WIDTH-1:0]              sym_period,
  input  logic [CNT_WIDTH-1:0]              period_tol,
  input  logic [CNT_WIDTH-1:0]              preamble_len,
  input  logic [CNT_WIDTH-1:0]              payload_len,
  output logic                              m00_axis_tvalid,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0] m00_axis_tdata,
  output logic                              m00_axis_tlast,
  input  logic                              m00_axis_tready,
  output logic                              locked,
  output logic [CNT_WIDTH-1:0]              frame_count,
  output logic                              overflow,
  output logic [1:0]                        state
);

  localparam int unsigned DW = C_M00_AXIS_TDATA_WIDTH;

  localparam logic [DW-1:0]        MinVal = {1'b1, {(DW-1){1'b0}}};
  localparam logic [DW-1:0]        MaxVal = {1'b0, {(DW-1){1'b1}}};
  localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH:0]   GapOne = (CNT_WIDTH + 1)'(1);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StSearch  = 2'd1,
    StTrack   = 2'd2,
    StPayload = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   per_q, per_d;
  logic [CNT_WIDTH-1:0]   tol_q, tol_d;
  logic [CNT_WIDTH-1:0]   plen_q, plen_d;
  logic [CNT_WIDTH-1:0]   paylen_q, paylen_d;
  logic                   pol_q, pol_d;
  logic [CNT_WIDTH-1:0]   trig_cnt_q, trig_cnt_d;
  // One bit wider than the counters so it can reach hi+1.
  logic [CNT_WIDTH:0]     gap_q, gap_d;
  logic [CNT_WIDTH-1:0]   pay_cnt_q, pay_cnt_d;
  logic [CNT_WIDTH-1:0]   frame_count_q, frame_count_d;
  logic                   overflow_q, overflow_d;
  logic                   tvalid_q, tvalid_d;
  logic [DW-1:0]          tdata_q, tdata_d;
  logic                   tlast_q, tlast_d;
  logic                   locked_q, locked_d;

  logic [CNT_WIDTH:0]     win_lo, win_hi, gap_inc;
  logic [CNT_WIDTH-1:0]   plen_eff, paylen_eff, trig_inc, pay_inc;
  logic [DW-1:0]          sample_corr;
  logic                   out_load_ok, in_window, pay_last;

  always_comb begin
    win_lo      = (per_q > tol_q) ? {1'b0, per_q - tol_q} : '0;
    win_hi      = {1'b0, per_q} + {1'b0, tol_q};
    gap_inc     = gap_q + GapOne;
    in_window   = (gap_inc >= win_lo) && (gap_inc <= win_hi);
    trig_inc    = trig_cnt_q + CntOne;
    pay_inc     = pay_cnt_q + CntOne;
    pay_last    = (pay_inc == paylen_q);
    plen_eff    = (preamble_len == '0) ? CntOne : preamble_len;
    paylen_eff  = (payload_len == '0) ? CntOne : payload_len;
    out_load_ok = !tvalid_q || m00_axis_tready;
    if (!pol_q) begin
      sample_corr = s00_axis_tdata;
    end else if (s00_axis_tdata == MinVal) begin
      sample_corr = MaxVal;
    end else begin
      sample_corr = -s00_axis_tdata;
    end
  end

  always_comb begin
    state_d       = state_q;
    per_d         = per_q;
    tol_d         = tol_q;
    plen_d        = plen_q;
    paylen_d      = paylen_q;
    pol_d         = pol_q;
    trig_cnt_d    = trig_cnt_q;
    gap_d         = gap_q;
    pay_cnt_d     = pay_cnt_q;
    frame_count_d = frame_count_q;
    overflow_d    = overflow_q;
    tvalid_d      = tvalid_q;
    tdata_d       = tdata_q;
    tlast_d       = tlast_q;

    if (tvalid_q && m00_axis_tready) begin
      tvalid_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (enable) state_d = StSearch;
      end
      StSearch: begin
        if (!enable) begin
          state_d = StIdle;
        end else if (s00_axis_tvalid && trigger[0]) begin
          per_d      = sym_period;
          tol_d      = period_tol;
          plen_d     = plen_eff;
          paylen_d   = paylen_eff;
          pol_d      = trigger[1];
          trig_cnt_d = CntOne;
          gap_d      = '0;
          pay_cnt_d  = '0;
          state_d    = (plen_eff == CntOne) ? StPayload : StTrack;
        end
      end
      StTrack: begin
        if (!enable) begin
          state_d = StIdle;
        end else if (s00_axis_tvalid) begin
          if (trigger[0] && in_window) begin
            trig_cnt_d = trig_inc;
            gap_d      = '0;
            pol_d      = trigger[1];
            if (trig_inc >= plen_q) begin
              pay_cnt_d = '0;
              state_d   = StPayload;
            end
          end else if (gap_inc > win_hi) begin
            state_d = StSearch;
          end else begin
            gap_d = gap_inc;
          end
        end
      end
      StPayload: begin
        if (s00_axis_tvalid) begin
          // A dropped sample still counts toward the frame length.
          if (out_load_ok) begin
            tvalid_d = 1'b1;
            tdata_d  = sample_corr;
            tlast_d  = pay_last;
          end else begin
            overflow_d = 1'b1;
          end
          if (pay_last) begin
            frame_count_d = frame_count_q + CntOne;
            state_d       = enable ? StSearch : StIdle;
          end else begin
            pay_cnt_d = pay_inc;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    locked_d = (state_d == StPayload);
  end

  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      state_q       <= StIdle;
      per_q         <= '0;
      tol_q         <= '0;
      plen_q        <= '0;
      paylen_q      <= '0;
      pol_q         <= 1'b0;
      trig_cnt_q    <= '0;
      gap_q         <= '0;
      pay_cnt_q     <= '0;
      frame_count_q <= '0;
      overflow_q    <= 1'b0;
      tvalid_q      <= 1'b0;
      tdata_q       <= '0;
      tlast_q       <= 1'b0;
      locked_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      per_q         <= per_d;
      tol_q         <= tol_d;
      plen_q        <= plen_d;
      paylen_q      <= paylen_d;
      pol_q         <= pol_d;
      trig_cnt_q    <= trig_cnt_d;
      gap_q         <= gap_d;
      pay_cnt_q     <= pay_cnt_d;
      frame_count_q <= frame_count_d;
      overflow_q    <= overflow_d;
      tvalid_q      <= tvalid_d;
      tdata_q       <= tdata_d;
      tlast_q       <= tlast_d;
      locked_q      <= locked_d;
    end
  end

  assign s00_axis_tready = 1'b1;
  assign m00_axis_tvalid = tvalid_q;
  assign m00_axis_tdata  = tdata_q;
  assign m00_axis_tlast  = tlast_q;
  assign locked          = locked_q;
  assign frame_count     = frame_count_q;
  assign overflow        = overflow_q;
  assign state           = state_q;

endmodule

// File: tb/tb_preamble_sync_controller.sv
// Directed bench for preamble_sync_controller with hand-computed expectations.
module tb_preamble_sync_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_tvalid;
  logic [31:0] s_tdata;
  logic        s_tready;
  logic [1:0]  trigger;
  logic        enable;
  logic [15:0] sym_period, period_tol, preamble_len, payload_len;
  logic        m_tvalid, m_tlast, m_tready;
  logic [31:0] m_tdata;
  logic        locked, overflow;
  logic [15:0] frame_count;
  logic [1:0]  state;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  preamble_sync_controller dut (
    .s00_axis_aclk    (clk),
    .s00_axis_aresetn (rst_n),
    .s00_axis_tvalid  (s_tvalid),
    .s00_axis_tdata   (s_tdata),
    .s00_axis_tready  (s_tready),
    .trigger          (trigger),
    .enable           (enable),
    .sym_period       (sym_period),
    .period_tol       (period_tol),
    .preamble_len     (preamble_len),
    .payload_len      (payload_len),
    .m00_axis_tvalid  (m_tvalid),
    .m00_axis_tdata   (m_tdata),
    .m00_axis_tlast   (m_tlast),
    .m00_axis_tready  (m_tready),
    .locked           (locked),
    .frame_count      (frame_count),
    .overflow         (overflow),
    .state            (state)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 ns after the edge.
  task automatic step(input logic v, input logic [31:0] d, input logic [1:0] trg);
    s_tvalid = v;
    s_tdata  = d;
    trigger  = trg;
    @(posedge clk);
    #1;
  endtask

  // Triggers at beats 0, 8, 16, 24 with spacing 8 (tol 1, preamble_len 4).
  task automatic preamble(input logic pol);
    for (int b = 0; b <= 24; b++) begin
      step(1'b1, 32'd0, (b % 8 == 0) ? {pol, 1'b1} : 2'b00);
      if (b == 0) check_eq("track_entry", 64'(state), 64'd2);
    end
    check_eq("lock_state", 64'(state), 64'd3);
    check_eq("locked", 64'(locked), 64'd1);
  endtask

  task automatic pay_beat(input string tag, input logic [31:0] d, input logic [31:0] exp_d,
                          input logic exp_last);
    step(1'b1, d, 2'b00);
    check_eq({tag, "_tvalid"}, 64'(m_tvalid), 64'd1);
    check_eq({tag, "_tdata"}, 64'(m_tdata), 64'(exp_d));
    check_eq({tag, "_tlast"}, 64'(m_tlast), 64'(exp_last));
  endtask

  logic [31:0] neg_in  [3];
  logic [31:0] neg_exp [3];

  initial begin
    rst_n        = 1'b0;
    enable       = 1'b0;
    s_tvalid     = 1'b0;
    s_tdata      = '0;
    trigger      = '0;
    m_tready     = 1'b1;
    sym_period   = 16'd8;
    period_tol   = 16'd1;
    preamble_len = 16'd4;
    payload_len  = 16'd5;
    #12;
    check_eq("rst_state", 64'(state), 64'd0);
    check_eq("rst_tvalid", 64'(m_tvalid), 64'd0);
    check_eq("rst_tdata", 64'(m_tdata), 64'd0);
    check_eq("rst_tlast", 64'(m_tlast), 64'd0);
    check_eq("rst_locked", 64'(locked), 64'd0);
    check_eq("rst_frames", 64'(frame_count), 64'd0);
    check_eq("rst_overflow", 64'(overflow), 64'd0);
    check_eq("s_tready", 64'(s_tready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 32'd0, 2'b00);
    check_eq("idle_hold", 64'(state), 64'd0);
    enable = 1'b1;
    step(1'b0, 32'd0, 2'b00);
    check_eq("search_entry", 64'(state), 64'd1);

    // Frame 1: polarity 0, samples 1..5.
    preamble(1'b0);
    for (int k = 1; k <= 5; k++) begin
      pay_beat("f1", 32'(k), 32'(k), (k == 5));
      if (k == 2) begin
        step(1'b0, 32'd0, 2'b00);
        check_eq("gap_beat_state", 64'(state), 64'd3);
        check_eq("gap_beat_tvalid", 64'(m_tvalid), 64'd0);
      end
    end
    check_eq("f1_frames", 64'(frame_count), 64'd1);
    check_eq("f1_state", 64'(state), 64'd1);
    check_eq("f1_unlocked", 64'(locked), 64'd0);
    step(1'b0, 32'd0, 2'b00);
    check_eq("f1_drain", 64'(m_tvalid), 64'd0);

    // Frame 2: polarity 1, negation with saturation.
    payload_len = 16'd3;
    neg_in[0] = 32'd7;         neg_exp[0] = 32'hFFFF_FFF9;
    neg_in[1] = 32'hFFFF_FFFD; neg_exp[1] = 32'd3;
    neg_in[2] = 32'h8000_0000; neg_exp[2] = 32'h7FFF_FFFF;
    preamble(1'b1);
    for (int k = 0; k < 3; k++) pay_beat("f2", neg_in[k], neg_exp[k], (k == 2));
    check_eq("f2_frames", 64'(frame_count), 64'd2);

    // Spacing 8, 8, 11: timeout at g=10, trigger at 27 restarts with trig_cnt=1.
    payload_len = 16'd2;
    for (int b = 0; b <= 51; b++) begin
      step(1'b1, 32'd0, (b == 0 || b == 8 || b == 16 || b == 27 || b == 35 || b == 43 ||
                         b == 51) ? 2'b01 : 2'b00);
      if (b == 25) check_eq("late_still_track", 64'(state), 64'd2);
      if (b == 26) check_eq("late_timeout", 64'(state), 64'd1);
      if (b == 27) check_eq("late_restart", 64'(state), 64'd2);
      if (b == 43) check_eq("late_cnt3", 64'(state), 64'd2);
    end
    check_eq("late_lock", 64'(state), 64'd3);
    pay_beat("f3a", 32'd11, 32'd11, 1'b0);
    pay_beat("f3b", 32'd12, 32'd12, 1'b1);
    check_eq("f3_frames", 64'(frame_count), 64'd3);

    // Spurious trigger at g=3 is ignored.
    for (int b = 0; b <= 24; b++) begin
      step(1'b1, 32'd0, (b == 0 || b == 8 || b == 11 || b == 16 || b == 24) ? 2'b01 : 2'b00);
      if (b == 16) check_eq("spur_track", 64'(state), 64'd2);
    end
    check_eq("spur_lock", 64'(state), 64'd3);
    pay_beat("f4a", 32'd21, 32'd21, 1'b0);
    pay_beat("f4b", 32'd22, 32'd22, 1'b1);
    check_eq("f4_frames", 64'(frame_count), 64'd4);

    // Backpressure: first sample held, two dropped.
    payload_len = 16'd3;
    preamble(1'b0);
    m_tready = 1'b0;
    pay_beat("bp1", 32'd10, 32'd10, 1'b0);
    check_eq("bp1_ovf", 64'(overflow), 64'd0);
    pay_beat("bp2", 32'd20, 32'd10, 1'b0);
    check_eq("bp2_ovf", 64'(overflow), 64'd1);
    pay_beat("bp3", 32'd30, 32'd10, 1'b0);
    check_eq("bp_frames", 64'(frame_count), 64'd5);
    check_eq("bp_state", 64'(state), 64'd1);
    m_tready = 1'b1;
    step(1'b0, 32'd0, 2'b00);
    check_eq("bp_drain", 64'(m_tvalid), 64'd0);

    // Enable drop in TRACK aborts; in PAYLOAD the frame completes.
    step(1'b1, 32'd0, 2'b01);
    check_eq("en_track", 64'(state), 64'd2);
    enable = 1'b0;
    step(1'b0, 32'd0, 2'b00);
    check_eq("en_abort", 64'(state), 64'd0);
    enable = 1'b1;
    step(1'b0, 32'd0, 2'b00);
    preamble(1'b0);
    pay_beat("en1", 32'd5, 32'd5, 1'b0);
    enable = 1'b0;
    pay_beat("en2", 32'd6, 32'd6, 1'b0);
    check_eq("en_no_trunc", 64'(state), 64'd3);
    pay_beat("en3", 32'd7, 32'd7, 1'b1);
    check_eq("en_idle", 64'(state), 64'd0);
    check_eq("en_frames", 64'(frame_count), 64'd6);
    enable = 1'b1;
    step(1'b0, 32'd0, 2'b00);

    // Zero lengths are treated as 1.
    preamble_len = 16'd0;
    payload_len  = 16'd0;
    step(1'b1, 32'd0, 2'b01);
    check_eq("zlen_direct", 64'(state), 64'd3);
    pay_beat("zlen", 32'd9, 32'd9, 1'b1);
    check_eq("zlen_state", 64'(state), 64'd1);
    check_eq("zlen_frames", 64'(frame_count), 64'd7);
    preamble_len = 16'd4;
    payload_len  = 16'd5;

    // Async reset mid-frame.
    preamble(1'b0);
    pay_beat("rst_mid", 32'd42, 32'd42, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_tvalid", 64'(m_tvalid), 64'd0);
    check_eq("arst_tdata", 64'(m_tdata), 64'd0);
    check_eq("arst_state", 64'(state), 64'd0);
    check_eq("arst_locked", 64'(locked), 64'd0);
    check_eq("arst_frames", 64'(frame_count), 64'd0);
    check_eq("arst_overflow", 64'(overflow), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
